// File: rtl/eth_pkg.sv
// eth_pkg: framing constants and generator state type shared by the frame transmit and receive blocks
package eth_pkg;
   localparam logic [7:0] PreambleOctet  = 8'hAA;
   localparam logic [7:0] SFDOctet       = 8'hAB;
   localparam int         PreambleLength = 7;
   localparam int         SFDLength      = 1;
   localparam int         MACLength      = 6;
   localparam int         PLLenLength    = 2;
   localparam int         FCSLength      = 4;
   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_LEN, S_PL, S_FCS, S_GAP
   } tx_state_t;
endpackage

// File: rtl/eth_tx_fifo.sv
// eth_tx_fifo: first-word-fall-through synchronous byte FIFO with occupancy count
module eth_tx_fifo #(
   parameter int DEPTH = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en_i,
   input  logic [7:0]                 wr_data_i,
   input  logic                       rd_en_i,
   output logic [7:0]                 rd_data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       rdy_o
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          push, pop;
   assign rdy_o     = count_q != (AW+1)'(DEPTH);
   assign push      = wr_en_i && rdy_o;
   assign pop       = rd_en_i && count_q != '0;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data_i;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
         rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
         count_q  <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end
endmodule

// File: rtl/eth_frame_tx.sv
// eth_frame_tx: buffered Ethernet-style frame generator with LRC FCS and inter-frame gap
module eth_frame_tx
   import eth_pkg::*;
#(
   parameter logic [47:0] DEST_MAC_ADDR = 48'h00_0a_95_9d_68_16,
   parameter logic [47:0] SRC_MAC_ADDR  = 48'h02_00_00_00_00_01,
   parameter int          FIFO_DEPTH    = 64,
   parameter int          IFG_CYCLES    = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic        in_vld,
   output logic        in_rdy,
   input  logic        tx_go,
   input  logic [15:0] tx_len,
   input  logic        rx_rdy,
   output logic [7:0]  data,
   output logic        start,
   output logic        busy,
   output logic        done,
   output logic        err
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   tx_state_t   state_q, state_d;
   logic [15:0] cnt_q, cnt_d, len_q, len_d, span;
   logic [7:0]  sum_q, sum_d, data_q, data_d, fifo_data;
   logic [5:0]  mac_sh;
   logic        start_q, start_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic        pop, last, in_lrc;
   logic [CW-1:0] fifo_cnt;
   eth_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (in_vld),
      .wr_data_i (in_data),
      .rd_en_i   (pop),
      .rd_data_o (fifo_data),
      .count_o   (fifo_cnt),
      .rdy_o     (in_rdy)
   );
   // outputs are computed from the next state so they appear registered in the cycle that state is entered
   always_comb begin
      span = state_q == S_PRE ? 16'(PreambleLength) :
             state_q == S_SFD ? 16'(SFDLength) :
             (state_q == S_DST || state_q == S_SRC) ? 16'(MACLength) :
             state_q == S_LEN ? 16'(PLLenLength) :
             state_q == S_PL  ? len_q :
             state_q == S_FCS ? 16'(FCSLength) : 16'(IFG_CYCLES);
      last    = cnt_q == span - 16'd1;
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      len_d   = len_q;
      err_d   = 1'b0;
      if (state_q == S_IDLE) begin
         cnt_d = '0;
         if (tx_go) begin
            if (tx_len == 16'd0 || tx_len > 16'(FIFO_DEPTH)) err_d = 1'b1;
            else if (rx_rdy && 16'(fifo_cnt) >= tx_len) begin
               state_d = S_PRE;
               len_d   = tx_len;
            end
         end
      end else if (last) begin
         cnt_d   = '0;
         state_d = state_q == S_GAP ? S_IDLE : tx_state_t'(state_q + 4'd1);
      end
      pop    = state_d == S_PL;
      mac_sh = {3'd5 - cnt_d[2:0], 3'b000};
      data_d = state_d == S_PRE ? PreambleOctet :
               state_d == S_SFD ? SFDOctet :
               state_d == S_DST ? 8'(DEST_MAC_ADDR >> mac_sh) :
               state_d == S_SRC ? 8'(SRC_MAC_ADDR >> mac_sh) :
               state_d == S_LEN ? (cnt_d[0] ? len_q[7:0] : len_q[15:8]) :
               state_d == S_PL  ? fifo_data :
               state_d == S_FCS ? ~sum_q + 8'd1 : 8'h00;
      in_lrc  = state_d == S_DST || state_d == S_SRC || state_d == S_LEN || state_d == S_PL;
      sum_d   = (state_q == S_IDLE ? 8'd0 : sum_q) + (in_lrc ? data_d : 8'd0);
      start_d = state_q == S_IDLE && state_d == S_PRE;
      done_d  = state_q != S_GAP && state_d == S_GAP;
      busy_d  = state_d != S_IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         sum_q   <= '0;
         data_q  <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         sum_q   <= sum_d;
         data_q  <= data_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end
   assign data  = data_q;
   assign start = start_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign err   = err_q;
endmodule
